multicycle_control: RTL

//  Moore FSM controller that sequences a shared-ALU, shared-memory multicycle RV32I datapath.

---
 rtl/multicycle_control.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a shared-ALU, shared-memory multicycle RV32I datapath (lw, sw, R, I, beq, jal).
// Optional feature macro: ILLEGAL_TRAP_EN (unsupported ops lock into a TRAP state until reset).
module multicycle_control #(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic [CNT_W-1:0] InstRet,
  output logic             Illegal
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMREAD = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECR   = 4'd6;
  localparam logic [3:0] S_EXECI   = 4'd7;
  localparam logic [3:0] S_ALUWB   = 4'd8;
  localparam logic [3:0] S_BEQ     = 4'd9;
  localparam logic [3:0] S_JAL     = 4'd10;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP    = 4'd11;
`endif

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             rdy;
  logic [1:0]       aluop;
  logic             pcw, irw, rw, mw;

  function automatic logic [2:0] alu_dec(input logic [1:0] aop, input logic [2:0] f3,
                                         input logic opb5, input logic f7b5);
    logic [2:0] r;
    r = 3'b000;
    case (aop)
      ALUOP_SUB:   r = 3'b001;
      ALUOP_FUNCT: begin
        case (f3)
          3'b000:  r = (opb5 & f7b5) ? 3'b001 : 3'b000;
          3'b010:  r = 3'b101;
          3'b110:  r = 3'b011;
          3'b111:  r = 3'b010;
          default: r = 3'b000;
        endcase
      end
      default:     r = 3'b000;
    endcase
    return r;
  endfunction

  // Without the handshake every memory access is assumed to complete in one cycle.
  assign rdy = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMREAD;
      S_MEMREAD: if (rdy) state_d = S_MEMWB;
      S_MEMWR:   if (rdy) state_d = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_JAL:     state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:    state_d = S_TRAP;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // A retirement is any edge that returns to FETCH, including DECODE NOPs.
  always_comb begin
    instret_d = instret_q;
    if (state_q != S_FETCH && state_d == S_FETCH) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    pcw       = 1'b0;
    irw       = 1'b0;
    rw        = 1'b0;
    mw        = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    aluop     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = rdy;
        pcw       = rdy;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: rw = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        aluop   = ALUOP_SUB;
        pcw     = Zero;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pcw     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Strobes are gated by reset so nothing commits while rst is held low.
  assign PCWrite    = pcw & rst;
  assign IRWrite    = irw & rst;
  assign RegWrite   = rw & rst;
  assign MemWrite   = mw & rst;
  assign ALUControl = alu_dec(aluop, funct3, op[5], funct7b5);
  assign InstRet    = instret_q;

`ifdef ILLEGAL_TRAP_EN
  assign Illegal = (state_q == S_TRAP);
`else
  assign Illegal = 1'b0;
`endif

endmodule
